// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader
//  Description : Boot-time program loader. Accepts a byte stream over a
//                valid/ready handshake and writes it to consecutive memory
//                addresses starting at a base address, holding the CPU in
//                reset meanwhile. The CPU is released a fixed number of
//                cycles after the last write.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i          system clock, all logic on rising edge
//    rst_ni         asynchronous active-low reset
//    start_i        1-cycle pulse: begin load (accepted only in IDLE or ERR)
//    base_addr_i    first write address, sampled on accepted start
//    len_i          byte count, sampled on accepted start (0 allowed)
//    in_valid_i     in_data_i valid
//    in_data_i      byte to write
//    in_ready_o     loader can accept a byte (LOAD state only)
//    mem_addr_o     write address to memory (holds last value)
//    mem_data_o     write data (holds last value)
//    mem_ena_o      bus ownership / chip enable during the write sequence
//    mem_wr_o       one-cycle write strobe
//    cpu_hold_o     1 = keep the CPU in reset
//    busy_o         loader is neither IDLE nor ERR
//    done_o         1-cycle pulse in the cycle cpu_hold_o falls
//    err_o          sticky inter-byte timeout flag, cleared by accepted start
// ============================================================================
module prog_loader #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 1024,
  parameter int HOLD_CYC    = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] len_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_ena_o,
  output logic              mem_wr_o,
  output logic              cpu_hold_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_SETUP   = 3'd2;
  localparam logic [2:0] S_STROBE  = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;
  localparam logic [2:0] S_RELEASE = 3'd5;
  localparam logic [2:0] S_ERR     = 3'd6;

  // Counter widths sized with +1 so a parameter value of 1 still yields a
  // legal non-zero width.
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam int HOLD_W = $clog2(HOLD_CYC + 1);

  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [2:0]        state_q,    state_d;
  logic [ADDR_W-1:0] base_q,     base_d;
  logic [ADDR_W-1:0] len_q,      len_d;
  logic [ADDR_W-1:0] count_q,    count_d;
  logic [IDLE_W-1:0] idle_q,     idle_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q,     done_d;
  logic              err_q,      err_d;

  // Bytes already written plus the one in flight; modulo 2^ADDR_W so the
  // comparison against len_q and the address sum wrap naturally.
  logic [ADDR_W-1:0] count_inc;
  assign count_inc = count_q + ADDR_W'(1);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    count_d    = count_q;
    idle_d     = idle_q;
    hold_cnt_d = hold_cnt_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    cpu_hold_d = cpu_hold_q;
    done_d     = 1'b0;
    err_d      = err_q;

    case (state_q)
      S_IDLE, S_ERR: begin
        if (start_i) begin
          base_d     = base_addr_i;
          len_d      = len_i;
          count_d    = '0;
          idle_d     = '0;
          hold_cnt_d = '0;
          err_d      = 1'b0;
          cpu_hold_d = 1'b1;
          // A zero-length load skips straight to the release countdown.
          state_d    = (len_i == '0) ? S_RELEASE : S_LOAD;
        end
      end

      S_LOAD: begin
        // in_ready_o is high throughout LOAD, so valid alone is a handshake.
        // A byte arriving on the final idle cycle takes priority over timeout.
        if (in_valid_i) begin
          mem_addr_d = base_q + count_q;
          mem_data_d = in_data_i;
          idle_d     = '0;
          state_d    = S_SETUP;
        end else if (idle_q == IDLE_LAST) begin
          err_d      = 1'b1;
          state_d    = S_ERR;
        end else begin
          idle_d     = idle_q + IDLE_W'(1);
        end
      end

      S_SETUP: begin
        state_d = S_STROBE;
      end

      S_STROBE: begin
        state_d = S_HOLD;
      end

      S_HOLD: begin
        count_d    = count_inc;
        idle_d     = '0;
        hold_cnt_d = '0;
        state_d    = (count_inc == len_q) ? S_RELEASE : S_LOAD;
      end

      S_RELEASE: begin
        // cpu_hold falls and done pulses together on entry to IDLE.
        if (hold_cnt_q == HOLD_LAST) begin
          cpu_hold_d = 1'b0;
          done_d     = 1'b1;
          state_d    = S_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers (reset aborts any sequence immediately, even mid-strobe)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      count_q    <= '0;
      idle_q     <= '0;
      hold_cnt_q <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      count_q    <= count_d;
      idle_q     <= idle_d;
      hold_cnt_q <= hold_cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: bus controls decode directly from the state register so they
  // drop with the asynchronous reset.
  // --------------------------------------------------------------------------
  assign in_ready_o = (state_q == S_LOAD);
  assign mem_ena_o  = (state_q == S_SETUP) || (state_q == S_STROBE) ||
                      (state_q == S_HOLD);
  assign mem_wr_o   = (state_q == S_STROBE);
  assign busy_o     = (state_q != S_IDLE) && (state_q != S_ERR);
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;
  assign cpu_hold_o = cpu_hold_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule
`default_nettype wire
